// File: rtl/thread_fetch.sv
// Two-thread fine-grained interleaved fetch stage with branch redirect and wrong-path squash.
// Optional per-thread fetch counters are built when FETCH_PERF_CNT_EN is defined.
module thread_fetch #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] T0_START = '0,
  parameter logic [PC_W-1:0] T1_START = PC_W'(100),
  parameter int              PC_STEP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         thread_en,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               br_valid,
  input  logic               br_tid,
  input  logic [PC_W-1:0]    br_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_tid,
  output logic [15:0]        fetch_cnt0,
  output logic [15:0]        fetch_cnt1
);

  logic [1:0][PC_W-1:0] pc_q, pc_d;
  logic                 curTid_q, curTid_d;
  logic                 outValid_q, outValid_d;
  logic [INSTR_W-1:0]   outInstr_q, outInstr_d;
  logic [PC_W-1:0]      outPc_q, outPc_d;
  logic                 outTid_q, outTid_d;

  logic            selValid;
  logic            sel;
  logic            advance;
  logic            load;
  logic            brHitsSel;
  logic            brHitsOut;
  logic [PC_W-1:0] brPc;

  // Round-robin pick falls back to the other thread when the current one is disabled.
  always_comb begin
    selValid  = |thread_en;
    sel       = thread_en[curTid_q] ? curTid_q : ~curTid_q;
    imem_pc   = selValid ? pc_q[sel] : pc_q[0];
    advance   = out_ready | ~outValid_q;
    load      = advance & selValid;
    brHitsSel = br_valid & (br_tid == sel);
    brHitsOut = br_valid & (br_tid == outTid_q);
    brPc      = br_target & ~PC_W'(1);
  end

  always_comb begin
    pc_d       = pc_q;
    curTid_d   = curTid_q;
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outPc_d    = outPc_q;
    outTid_d   = outTid_q;
    if (load) begin
      outInstr_d = imem_instr;
      outPc_d    = pc_q[sel];
      outTid_d   = sel;
      outValid_d = ~brHitsSel;
      pc_d[sel]  = pc_q[sel] + PC_W'(PC_STEP);
      curTid_d   = ~sel;
    end else if (advance) begin
      outValid_d = 1'b0;
    end else if (outValid_q && brHitsOut) begin
      outValid_d = 1'b0;
    end
    // The redirect is applied last so it overrides a same-cycle increment.
    if (br_valid) begin
      pc_d[br_tid] = brPc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q[0]    <= T0_START;
      pc_q[1]    <= T1_START;
      curTid_q   <= 1'b0;
      outValid_q <= 1'b0;
      outInstr_q <= '0;
      outPc_q    <= '0;
      outTid_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      curTid_q   <= curTid_d;
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outPc_q    <= outPc_d;
      outTid_q   <= outTid_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_instr = outInstr_q;
  assign out_pc    = outPc_q;
  assign out_tid   = outTid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Only live (non-squashed) loads are counted; counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (load && !brHitsSel) begin
      if (!sel && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (sel && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign fetch_cnt0 = cnt0_q;
  assign fetch_cnt1 = cnt1_q;
`else
  assign fetch_cnt0 = '0;
  assign fetch_cnt1 = '0;
`endif

endmodule

// File: tb/tb_thread_fetch.sv
// Scoreboard bench for thread_fetch: a queue-based reference model predicts accepted outputs,
// a separate monitor compares them on every handshake.
module tb_thread_fetch;

  logic        clk;
  logic        rst_n;
  logic [1:0]  thread_en;
  logic [7:0]  imem_pc;
  logic [15:0] imem_instr;
  logic        br_valid;
  logic        br_tid;
  logic [7:0]  br_target;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        out_tid;
  logic [15:0] fetch_cnt0;
  logic [15:0] fetch_cnt1;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        tid;
  } item_t;

  item_t       sbq[$];
  logic [7:0]  mpc[2];
  logic        mcur;
  logic        mvalid;
  logic        mtid;
  logic [15:0] mcnt[2];

  thread_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .thread_en  (thread_en),
    .imem_pc    (imem_pc),
    .imem_instr (imem_instr),
    .br_valid   (br_valid),
    .br_tid     (br_tid),
    .br_target  (br_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_tid    (out_tid),
    .fetch_cnt0 (fetch_cnt0),
    .fetch_cnt1 (fetch_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [7:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  assign imem_instr = memWord(imem_pc);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passCount++;
  endtask

  task automatic modelReset();
    sbq.delete();
    mpc[0]  = 8'd0;
    mpc[1]  = 8'd100;
    mcur    = 1'b0;
    mvalid  = 1'b0;
    mtid    = 1'b0;
    mcnt[0] = 16'd0;
    mcnt[1] = 16'd0;
  endtask

  // One clock of the reference model, evaluated from the inputs currently driven.
  task automatic modelStep();
    logic  has;
    logic  s;
    logic  adv;
    logic  squash;
    item_t it;
    has = thread_en[mcur] || thread_en[!mcur];
    s   = thread_en[mcur] ? mcur : !mcur;
    adv = out_ready || !mvalid;
    if (adv && has) begin
      squash   = br_valid && (br_tid == s);
      it.pc    = mpc[s];
      it.instr = memWord(mpc[s]);
      it.tid   = s;
      mpc[s]   = mpc[s] + 8'd2;
      mcur     = !s;
      mtid     = s;
      mvalid   = !squash;
      if (!squash) begin
        sbq.push_back(it);
        if (mcnt[s] != 16'hFFFF) mcnt[s] = mcnt[s] + 16'd1;
      end
    end else if (adv) begin
      mvalid = 1'b0;
    end else if (mvalid && br_valid && br_tid == mtid) begin
      if (sbq.size() > 0) void'(sbq.pop_back());
      mvalid = 1'b0;
    end
    if (br_valid) mpc[br_tid] = {br_target[7:1], 1'b0};
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic rdy, input logic bv,
                               input logic btid, input logic [7:0] tgt);
    @(negedge clk);
    #1;
    thread_en = en;
    out_ready = rdy;
    br_valid  = bv;
    br_tid    = btid;
    br_target = tgt;
    #2;
    modelStep();
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    thread_en = 2'b00;
    out_ready = 1'b0;
    br_valid  = 1'b0;
    modelReset();
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_pc", 32'(out_pc), 32'd0);
    checkOutput("reset out_instr", 32'(out_instr), 32'd0);
    checkOutput("reset out_tid", 32'(out_tid), 32'd0);
    checkOutput("reset fetch_cnt0", 32'(fetch_cnt0), 32'd0);
    checkOutput("reset fetch_cnt1", 32'(fetch_cnt1), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    modelStep();
  endtask

  // Monitor: compares DUT outputs against the model and pops the scoreboard on handshakes.
  initial begin
    item_t      it;
    logic [7:0] expPc;
    forever begin
      @(negedge clk);
      #2;
      checkOutput("out_valid", 32'(out_valid), 32'(mvalid));
      if (thread_en[mcur])       expPc = mpc[mcur];
      else if (thread_en[!mcur]) expPc = mpc[!mcur];
      else                       expPc = mpc[0];
      checkOutput("imem_pc", 32'(imem_pc), 32'(expPc));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL handshake: got pc %0h with no expected entry at %0t", out_pc, $time);
        end else begin
          it = sbq.pop_front();
          checkOutput("out_pc", 32'(out_pc), 32'(it.pc));
          checkOutput("out_instr", 32'(out_instr), 32'(it.instr));
          checkOutput("out_tid", 32'(out_tid), 32'(it.tid));
        end
      end
`ifdef FETCH_PERF_CNT_EN
      checkOutput("fetch_cnt0", 32'(fetch_cnt0), 32'(mcnt[0]));
      checkOutput("fetch_cnt1", 32'(fetch_cnt1), 32'(mcnt[1]));
`else
      checkOutput("fetch_cnt0", 32'(fetch_cnt0), 32'd0);
      checkOutput("fetch_cnt1", 32'(fetch_cnt1), 32'd0);
`endif
    end
  end

  initial begin
    rst_n     = 1'b0;
    thread_en = 2'b00;
    out_ready = 1'b0;
    br_valid  = 1'b0;
    br_tid    = 1'b0;
    br_target = 8'd0;
    modelReset();
    resetDut();

    // Interleaved fetch, then a three-cycle stall while pc 2 is held.
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 8'd0);

    // Squash a held thread-1 instruction with even and odd targets.
    applyStimulus(2'b11, 1'b0, 1'b1, 1'b1, 8'd110);
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(2'b11, 1'b0, 1'b1, 1'b1, 8'd111);
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 8'd0);

    // Single-thread and idle operation.
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 8'd0);

    // PC wrap on thread 0.
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0, 8'd254);
    for (int i = 0; i < 6; i++) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 8'd0);

    // Ten clean cycles from reset with one thread-1 squash.
    resetDut();
    for (int i = 0; i < 10; i++)
      applyStimulus(2'b11, 1'b1, (i == 3), 1'b1, 8'd40);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) resetDut();
      applyStimulus(($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) == 0),
                    1'($urandom),
                    8'($urandom));
    end

    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
